fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core. It owns the program counter, issues instruction-memory requests over a request/grant + response-valid handshake, and buffers returned instructions in a small in-order queue feeding decode. It consumes the branch-redirect decision (PCSrc) and branch target produced downstream, flushing stale fetches on a taken branch.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 57 +++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction buffer between fetch and decode; flush wins over push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int CNT_W = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(QDEPTH);

  entry_t           mem [QDEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_W'(QDEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Entries are cleared on reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr_reg] <= push_data;
        wr_ptr_reg      <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, buffers responses for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    QDEPTH     = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pcsrc_i,
  input  logic [ADDR_WIDTH-1:0] pctarget_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pcplus4_o,
  input  logic                  instr_ready_i
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  state_e                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_WIDTH-1:0] resp_pc_reg, resp_pc_next;
  logic [CNT_W-1:0]      outstanding_reg, outstanding_next;
  logic [CNT_W-1:0]      discard_reg, discard_next;
  logic [CNT_W:0]        occupancy;
  logic [CNT_W-1:0]      q_count;
  logic                  q_full, q_empty, q_push, q_pop;
  logic                  fire, drop;
  logic [ADDR_WIDTH-1:0] target_aligned;
  entry_t                q_head, q_data;

  assign target_aligned = {pctarget_i[ADDR_WIDTH-1:2], 2'b00};
  assign occupancy      = {1'b0, outstanding_reg} + {1'b0, q_count};

  always_comb begin
    state_next       = state_reg;
    imem_req_o       = 1'b0;
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    discard_next     = discard_reg;
    if (state_reg == BOOT) state_next = RUN;
    // Credit covers both in-flight requests and buffered entries, so a response always has a slot.
    if (state_reg == RUN && occupancy < (CNT_W+1)'(QDEPTH)) imem_req_o = 1'b1;
    fire             = imem_req_o & imem_gnt_i;
    drop             = imem_rvalid_i && (discard_reg != '0);
    q_push           = imem_rvalid_i && !drop && !pcsrc_i;
    outstanding_next = outstanding_reg + CNT_W'(fire) - CNT_W'(imem_rvalid_i);
    if (fire) fetch_pc_next = fetch_pc_reg + ADDR_WIDTH'(4);
    if (q_push) resp_pc_next = resp_pc_reg + ADDR_WIDTH'(4);
    if (drop) discard_next = discard_reg - CNT_W'(1);
    // Everything still in flight after this edge belongs to the abandoned path.
    if (pcsrc_i) begin
      fetch_pc_next = target_aligned;
      resp_pc_next  = target_aligned;
      discard_next  = outstanding_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= BOOT;
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  assign q_data.pc    = resp_pc_reg;
  assign q_data.instr = imem_rdata_i;
  assign q_pop        = ~q_empty & instr_ready_i;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data (q_data),
    .pop       (q_pop),
    .flush     (pcsrc_i),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign imem_addr_o   = fetch_pc_reg;
  assign instr_valid_o = ~q_empty;
  assign instr_o       = q_head.instr;
  assign pc_o          = q_head.pc;
  assign pcplus4_o     = q_head.pc + ADDR_WIDTH'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory that returns the address as data.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcsrc_i;
  logic [31:0] pctarget_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pcplus4_o;
  logic        instr_ready_i;

  logic        mem_hold;
  logic [31:0] pend_q[$];
  int          checks = 0;
  int          errors = 0;
  int          grants = 0;
  int          consumed = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pcsrc_i       (pcsrc_i),
    .pctarget_i    (pctarget_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pcplus4_o     (pcplus4_o),
    .instr_ready_i (instr_ready_i)
  );

  // Memory: in order, responds the cycle after grant unless held.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q.delete();
      imem_rvalid_i <= 1'b0;
      imem_rdata_i  <= 32'h0;
    end else begin
      if (imem_req_o && imem_gnt_i) pend_q.push_back(imem_addr_o);
      if (!mem_hold && pend_q.size() > 0) begin
        imem_rvalid_i <= 1'b1;
        imem_rdata_i  <= pend_q.pop_front();
      end else begin
        imem_rvalid_i <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && imem_req_o && imem_gnt_i) grants++;
    if (rst_n) begin
      checks++;
      assert (!(dut.u_queue.push && dut.u_queue.full)) else begin
        errors++;
        $error("FAIL push_when_full: observed 1 expected 0");
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the head, check it against the expected PC, then pop it.
  task automatic consume(input logic [31:0] exp_pc);
    int n = 0;
    logic [31:0] exp_p4;
    exp_p4 = exp_pc + 32'd4;
    while (!instr_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("head_valid", 32'(instr_valid_o), 32'd1);
    chk("instr", instr_o, exp_pc);
    chk("pc", pc_o, exp_pc);
    chk("pcplus4", pcplus4_o, exp_p4);
    instr_ready_i = 1'b1;
    @(negedge clk);
    instr_ready_i = 1'b0;
    consumed++;
  endtask

  task automatic run_free(input int n);
    instr_ready_i = 1'b1;
    repeat (n) @(negedge clk);
    instr_ready_i = 1'b0;
  endtask

  initial begin
    pcsrc_i = 1'b0; pctarget_i = 32'h0; imem_gnt_i = 1'b0;
    instr_ready_i = 1'b0; mem_hold = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_pcplus4", pcplus4_o, 32'h4);

    // Startup: BOOT cycle, then back-to-back grants until credits run out.
    imem_gnt_i = 1'b1;
    rst_n = 1'b1;
    #1 chk("boot_req", 32'(imem_req_o), 32'd0);
    @(negedge clk);
    chk("c1_req", 32'(imem_req_o), 32'd1);
    chk("c1_addr", imem_addr_o, 32'h0);
    chk("c1_valid", 32'(instr_valid_o), 32'd0);
    @(negedge clk);
    chk("c2_req", 32'(imem_req_o), 32'd1);
    chk("c2_addr", imem_addr_o, 32'h4);
    chk("c2_valid", 32'(instr_valid_o), 32'd0);
    @(negedge clk);
    chk("c3_req", 32'(imem_req_o), 32'd0);
    chk("c3_addr", imem_addr_o, 32'h8);
    chk("c3_valid", 32'(instr_valid_o), 32'd1);
    consume(32'h0);
    consume(32'h4);
    consume(32'h8);

    // Decode stalled: credits cap fetched-but-unconsumed at two.
    repeat (10) @(negedge clk);
    chk("stall_req", 32'(imem_req_o), 32'd0);
    chk("stall_inflight", 32'(grants - consumed), 32'd2);
    consume(32'hC);
    consume(32'h10);
    consume(32'h14);
    consume(32'h18);

    // Redirect with two responses still outstanding.
    mem_hold = 1'b1;
    run_free(8);
    chk("pre_redir_valid", 32'(instr_valid_o), 32'd0);
    chk("pre_redir_req", 32'(imem_req_o), 32'd0);
    pcsrc_i = 1'b1; pctarget_i = 32'h103; mem_hold = 1'b0;
    @(negedge clk);
    pcsrc_i = 1'b0;
    chk("redir_addr", imem_addr_o, 32'h100);
    chk("redir_valid", 32'(instr_valid_o), 32'd0);
    chk("redir_discard", 32'(dut.discard_reg), 32'd2);
    consume(32'h100);
    consume(32'h104);

    // Redirect in the same cycle as a response and a grant.
    imem_gnt_i = 1'b0;
    run_free(6);
    imem_gnt_i = 1'b1;
    @(negedge clk);
    chk("same_rvalid", 32'(imem_rvalid_i), 32'd1);
    chk("same_req", 32'(imem_req_o), 32'd1);
    pcsrc_i = 1'b1; pctarget_i = 32'h200;
    @(negedge clk);
    pcsrc_i = 1'b0;
    chk("same_addr", imem_addr_o, 32'h200);
    chk("same_valid", 32'(instr_valid_o), 32'd0);
    chk("same_discard", 32'(dut.discard_reg), 32'd1);
    consume(32'h200);
    consume(32'h204);

    // Grant withheld at the top of the address space, then wrap.
    imem_gnt_i = 1'b0;
    run_free(6);
    pcsrc_i = 1'b1; pctarget_i = 32'hFFFF_FFFC;
    @(negedge clk);
    pcsrc_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("nognt_addr", imem_addr_o, 32'hFFFF_FFFC);
      chk("nognt_req", 32'(imem_req_o), 32'd1);
      @(negedge clk);
    end
    imem_gnt_i = 1'b1;
    consume(32'hFFFF_FFFC);
    consume(32'h0);

    // Asynchronous reset mid-stream, then restart from the reset PC.
    run_free(3);
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req_o), 32'd0);
    chk("arst_addr", imem_addr_o, 32'h0);
    chk("arst_valid", 32'(instr_valid_o), 32'd0);
    chk("arst_instr", instr_o, 32'h0);
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_pcplus4", pcplus4_o, 32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("reboot_req", 32'(imem_req_o), 32'd0);
    @(negedge clk);
    chk("restart_req", 32'(imem_req_o), 32'd1);
    chk("restart_addr", imem_addr_o, 32'h0);
    consume(32'h0);
    consume(32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
